// File: rtl/custom_apb_pwm_led.sv
// rtl/custom_apb_pwm_led.sv - APB3 multi-channel PWM LED driver with double-buffered period/duty
module custom_apb_pwm_led #(
    parameter int ADDRWIDTH = 12,
    parameter int CH        = 4
) (
    input  logic                 pclk,
    input  logic                 preset,
    input  logic                 psel,
    input  logic [ADDRWIDTH-1:0] paddr,
    input  logic                 penable,
    input  logic                 pwrite,
    input  logic [31:0]          pwdata,
    output logic [31:0]          prdata,
    output logic                 pready,
    output logic                 pslverr,
    output logic [CH-1:0]        led,
    output logic                 PWM_IRQ
);

    logic        r_en;
    logic        r_ie;
    logic        r_pd;
    logic [15:0] r_period;
    logic [15:0] r_presc;
    logic [15:0] r_duty [CH];
    logic [15:0] r_pre_cnt;
    logic [15:0] r_cnt;
    logic [15:0] r_p_act;
    logic [15:0] r_duty_act [CH];
    logic [31:0] r_prdata;
    logic [CH-1:0] r_led;

    logic          w_wr;
    logic          w_rd;
    logic          w_sel_ctrl;
    logic          w_sel_period;
    logic          w_sel_presc;
    logic          w_sel_status;
    logic [CH-1:0] w_sel_duty;
    logic [15:0]   w_period_nxt;
    logic [15:0]   w_duty_nxt [CH];
    logic [31:0]   w_rdata;
    logic          w_tick;
    logic          w_bound;
    logic          w_unused;

    assign w_wr = psel & penable & pwrite;
    assign w_rd = psel & ~penable & ~pwrite;

    assign w_sel_ctrl   = (paddr == ADDRWIDTH'(32'h000));
    assign w_sel_period = (paddr == ADDRWIDTH'(32'h004));
    assign w_sel_presc  = (paddr == ADDRWIDTH'(32'h008));
    assign w_sel_status = (paddr == ADDRWIDTH'(32'h00C));

    always_comb begin
        for (int i = 0; i < CH; i++) begin
            w_sel_duty[i] = (paddr == ADDRWIDTH'(32'h010 + 32'(4 * i)));
        end
    end

    // Staging values as they will be after this edge, so a write landing on
    // the boundary edge is captured by that same load.
    always_comb begin
        w_period_nxt = r_period;
        if (w_wr && w_sel_period) begin
            w_period_nxt = pwdata[15:0];
        end
        for (int i = 0; i < CH; i++) begin
            w_duty_nxt[i] = r_duty[i];
            if (w_wr && w_sel_duty[i]) begin
                w_duty_nxt[i] = pwdata[15:0];
            end
        end
    end

    always_comb begin
        w_rdata = 32'h0;
        if (w_sel_ctrl)   w_rdata = {30'h0, r_ie, r_en};
        if (w_sel_period) w_rdata = {16'h0, r_period};
        if (w_sel_presc)  w_rdata = {16'h0, r_presc};
        if (w_sel_status) w_rdata = {31'h0, r_pd};
        for (int i = 0; i < CH; i++) begin
            if (w_sel_duty[i]) w_rdata = {16'h0, r_duty[i]};
        end
    end

    assign w_tick  = r_en & (r_pre_cnt == r_presc);
    assign w_bound = w_tick & (r_cnt == r_p_act);

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_en      <= 1'b0;
            r_ie      <= 1'b0;
            r_pd      <= 1'b0;
            r_period  <= 16'hFFFF;
            r_presc   <= 16'h0;
            r_pre_cnt <= 16'h0;
            r_cnt     <= 16'h0;
            r_p_act   <= 16'hFFFF;
            r_prdata  <= 32'h0;
            r_led     <= '0;
            for (int i = 0; i < CH; i++) begin
                r_duty[i]     <= 16'h0;
                r_duty_act[i] <= 16'h0;
            end
        end else begin
            if (w_rd) begin
                r_prdata <= w_rdata;
            end
            if (w_wr && w_sel_ctrl) begin
                r_en <= pwdata[0];
                r_ie <= pwdata[1];
            end
            if (w_wr && w_sel_presc) begin
                r_presc <= pwdata[15:0];
            end
            r_period <= w_period_nxt;
            for (int i = 0; i < CH; i++) begin
                r_duty[i] <= w_duty_nxt[i];
            end

            // A boundary set beats a same-edge software clear.
            if (w_bound) begin
                r_pd <= 1'b1;
            end else if (w_wr && w_sel_status && pwdata[0]) begin
                r_pd <= 1'b0;
            end

            if (!r_en) begin
                r_pre_cnt <= 16'h0;
                r_cnt     <= 16'h0;
                r_p_act   <= w_period_nxt;
                for (int i = 0; i < CH; i++) begin
                    r_duty_act[i] <= w_duty_nxt[i];
                end
            end else if (w_tick) begin
                r_pre_cnt <= 16'h0;
                if (w_bound) begin
                    r_cnt   <= 16'h0;
                    r_p_act <= w_period_nxt;
                    for (int i = 0; i < CH; i++) begin
                        r_duty_act[i] <= w_duty_nxt[i];
                    end
                end else begin
                    r_cnt <= r_cnt + 16'h1;
                end
            end else begin
                r_pre_cnt <= r_pre_cnt + 16'h1;
            end

            for (int i = 0; i < CH; i++) begin
                r_led[i] <= r_en & (r_cnt < r_duty_act[i]);
            end
        end
    end

    assign w_unused = ^pwdata[31:16];

    assign prdata  = r_prdata;
    assign pready  = 1'b1;
    assign pslverr = 1'b0;
    assign led     = r_led;
    assign PWM_IRQ = r_pd & r_ie;

endmodule

// File: tb/tb_custom_apb_pwm_led.sv
// tb/tb_custom_apb_pwm_led.sv - self-checking bench for custom_apb_pwm_led
module tb_custom_apb_pwm_led;

    localparam int CH = 4;
    localparam int AW = 12;

    logic          pclk = 1'b0;
    logic          preset;
    logic          psel;
    logic [AW-1:0] paddr;
    logic          penable;
    logic          pwrite;
    logic [31:0]   pwdata;
    logic [31:0]   prdata;
    logic          pready;
    logic          pslverr;
    logic [CH-1:0] led;
    logic          irq;

    always #5 pclk = ~pclk;

    custom_apb_pwm_led #(.ADDRWIDTH(AW), .CH(CH)) dut (
        .pclk    (pclk),
        .preset  (preset),
        .psel    (psel),
        .paddr   (paddr),
        .penable (penable),
        .pwrite  (pwrite),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .led     (led),
        .PWM_IRQ (irq)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit          wr;
        logic [11:0] addr;
        logic [31:0] data;
    } vec_t;

    vec_t tv [24];
    int   n_tv;

    int cfg_presc;
    int cfg_per;
    int cfg_duty [CH];
    int stg [CH];
    int act [CH];
    bit pd_m;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic apb_write(input logic [AW-1:0] a, input logic [31:0] d);
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [AW-1:0] a, output logic [31:0] d);
        psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
        @(posedge pclk); #1;
        penable = 1'b1;
        d = prdata;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    // Enable with the cfg_* values and compare every edge against the
    // closed-form waveform: cnt at edge m is floor(m/(PRESC+1)) mod (P+1),
    // and edge m ends a period when (m+1) is a multiple of (P+1)*(PRESC+1).
    // One optional write (DUTY or STATUS) commits at edge wm.
    task automatic run(input bit do_cfg, input bit ie, input int ncyc, input int wm,
                       input logic [AW-1:0] waddr, input logic [31:0] wdata);
        int cnt;
        int plen;
        logic [CH-1:0] lexp;
        if (do_cfg) begin
            apb_write(12'h000, 32'h0);
            apb_write(12'h00C, 32'h1);
            apb_write(12'h008, 32'(cfg_presc));
            apb_write(12'h004, 32'(cfg_per));
            for (int i = 0; i < CH; i++) apb_write(AW'(16 + 4 * i), 32'(cfg_duty[i]));
            pd_m = 1'b0;
        end
        for (int i = 0; i < CH; i++) begin
            stg[i] = cfg_duty[i];
            act[i] = cfg_duty[i];
        end
        apb_write(12'h000, {30'h0, ie, 1'b1});
        plen = (cfg_per + 1) * (cfg_presc + 1);
        for (int m = 0; m < ncyc; m++) begin
            if (m == wm - 1) begin
                psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = waddr; pwdata = wdata;
            end
            if (m == wm) penable = 1'b1;
            if (m == wm + 1) begin
                psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
            end
            @(posedge pclk); #1;
            cnt = (m / (cfg_presc + 1)) % (cfg_per + 1);
            for (int i = 0; i < CH; i++) lexp[i] = (cnt < act[i]);
            if (m == wm) begin
                for (int i = 0; i < CH; i++)
                    if (waddr == AW'(16 + 4 * i)) stg[i] = int'(wdata[15:0]);
            end
            if (((m + 1) % plen) == 0) begin
                for (int i = 0; i < CH; i++) act[i] = stg[i];
                pd_m = 1'b1;
            end else if (m == wm && waddr == 12'h00C && wdata[0]) begin
                pd_m = 1'b0;
            end
            check($sformatf("led_m%0d", m), 32'(led), 32'(lexp));
            check($sformatf("irq_m%0d", m), 32'(irq), 32'(pd_m & ie));
        end
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int n;
        int wm;
        int kind;
        logic [AW-1:0] wa;
        logic [31:0] wd;
        bit ie;

        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0;
        repeat (3) @(posedge pclk);
        #1 preset = 1'b0;

        check("rst_led", 32'(led), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_prdata", prdata, 32'h0);
        check("pready", 32'(pready), 32'h1);
        check("pslverr", 32'(pslverr), 32'h0);

        n_tv = 0;
        tv[n_tv++] = '{0, 12'h000, 32'h0};
        tv[n_tv++] = '{0, 12'h004, 32'h0000_FFFF};
        tv[n_tv++] = '{0, 12'h008, 32'h0};
        tv[n_tv++] = '{0, 12'h00C, 32'h0};
        tv[n_tv++] = '{0, 12'h010, 32'h0};
        tv[n_tv++] = '{0, 12'h014, 32'h0};
        tv[n_tv++] = '{0, 12'h018, 32'h0};
        tv[n_tv++] = '{0, 12'h01C, 32'h0};
        tv[n_tv++] = '{0, 12'h020, 32'h0};
        tv[n_tv++] = '{1, 12'h004, 32'h0001_2345};
        tv[n_tv++] = '{0, 12'h004, 32'h0000_2345};
        tv[n_tv++] = '{0, 12'h804, 32'h0};
        tv[n_tv++] = '{0, 12'h006, 32'h0};
        tv[n_tv++] = '{1, 12'h008, 32'hFFFF_0007};
        tv[n_tv++] = '{0, 12'h008, 32'h0000_0007};
        tv[n_tv++] = '{1, 12'h000, 32'hFFFF_FFFE};
        tv[n_tv++] = '{0, 12'h000, 32'h0000_0002};
        tv[n_tv++] = '{1, 12'h01C, 32'h0000_ABCD};
        tv[n_tv++] = '{0, 12'h01C, 32'h0000_ABCD};
        tv[n_tv++] = '{1, 12'h400, 32'h0000_0055};
        tv[n_tv++] = '{0, 12'h400, 32'h0};
        tv[n_tv++] = '{1, 12'h00C, 32'hFFFF_FFFF};
        tv[n_tv++] = '{0, 12'h00C, 32'h0};
        tv[n_tv++] = '{1, 12'h000, 32'h0};
        for (int k = 0; k < n_tv; k++) begin
            if (tv[k].wr) begin
                apb_write(tv[k].addr, tv[k].data);
            end else begin
                apb_read(tv[k].addr, rd);
                check($sformatf("reg_%03h_v%0d", tv[k].addr, k), rd, tv[k].data);
            end
        end
        check("irq_ie_only", 32'(irq), 32'h0);

        // basic waveform
        cfg_presc = 0; cfg_per = 9;
        cfg_duty[0] = 3; cfg_duty[1] = 0; cfg_duty[2] = 10; cfg_duty[3] = 5;
        run(1, 0, 30, -1, 12'h0, 32'h0);

        // disable mid-period, then restart from cnt 0 without reconfiguring
        apb_write(12'h000, 32'h0);
        @(posedge pclk); #1;
        check("led_after_disable", 32'(led), 32'h0);
        run(0, 0, 25, -1, 12'h0, 32'h0);

        // prescaler, period 12, boundaries 12 cycles apart (clear in between)
        cfg_presc = 2; cfg_per = 3;
        cfg_duty[0] = 2; cfg_duty[1] = 4; cfg_duty[2] = 0; cfg_duty[3] = 1;
        run(1, 1, 40, 15, 12'h00C, 32'h1);

        // shadowing: DUTY0 3 -> 7 at cnt = 2 of the second period
        cfg_presc = 0; cfg_per = 9;
        cfg_duty[0] = 3; cfg_duty[1] = 0; cfg_duty[2] = 10; cfg_duty[3] = 5;
        run(1, 0, 40, 12, 12'h010, 32'h7);
        apb_read(12'h010, rd);
        check("duty0_readback", rd, 32'h7);

        // write landing on the boundary edge is taken by that load
        run(1, 0, 30, 9, 12'h014, 32'h4);

        // interrupt: clear on boundary edge keeps PD, write 0 has no effect
        run(1, 1, 25, 9, 12'h00C, 32'h1);
        run(1, 1, 25, 12, 12'h00C, 32'h0);

        // randomized configurations
        for (int k = 0; k < 10; k++) begin
            cfg_presc = int'($urandom_range(0, 3));
            cfg_per   = int'($urandom_range(0, 6));
            for (int i = 0; i < CH; i++) cfg_duty[i] = int'($urandom_range(0, 8));
            ie   = 1'($urandom_range(0, 1));
            n    = 2 * (cfg_per + 1) * (cfg_presc + 1) + 4;
            wm   = int'($urandom_range(1, n - 1));
            kind = int'($urandom_range(0, 2));
            wa   = (kind == 2) ? 12'h00C : AW'(16 + 4 * int'($urandom_range(0, CH - 1)));
            wd   = (kind == 2) ? 32'h1 : 32'($urandom_range(0, 8));
            if (kind == 0) wm = -1;
            run(1, ie, n, wm, wa, wd);
        end

        // reset while running with IRQ asserted and an APB write in flight
        cfg_presc = 0; cfg_per = 9;
        cfg_duty[0] = 3; cfg_duty[1] = 0; cfg_duty[2] = 10; cfg_duty[3] = 5;
        run(1, 1, 15, -1, 12'h0, 32'h0);
        apb_read(12'h004, rd);
        check("period_read_running", rd, 32'h9);
        check("irq_before_reset", 32'(irq), 32'h1);
        preset = 1'b1; psel = 1'b1; penable = 1'b1; pwrite = 1'b1;
        paddr = 12'h010; pwdata = 32'h5;
        @(posedge pclk); #1;
        preset = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        check("prst_led", 32'(led), 32'h0);
        check("prst_irq", 32'(irq), 32'h0);
        check("prst_prdata", prdata, 32'h0);
        apb_read(12'h000, rd); check("prst_ctrl", rd, 32'h0);
        apb_read(12'h004, rd); check("prst_period", rd, 32'h0000_FFFF);
        apb_read(12'h00C, rd); check("prst_status", rd, 32'h0);
        apb_read(12'h010, rd); check("prst_duty0", rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/custom_apb_pwm_led.md
# custom_apb_pwm_led

APB3 slave that drives the board LED outputs. It is the output-direction companion to the debounced button-input peripheral on the same APB segment. Software programs a shared prescaler, a shared period and a per-channel duty. The block generates CH PWM outputs and raises a level interrupt at each period boundary. Period and duty writes are double-buffered so a running waveform never glitches.

## Interface
- ADDRWIDTH, 12, APB address width; fully decoded.
- CH, 4, number of PWM channels, 1..8.

Ports (`name  direction  width  meaning`):
- pclk  in  1  system clock; the only clock.
- preset  in  1  reset; synchronous, active-high.
- psel  in  1  APB select.
- paddr  in  ADDRWIDTH  APB byte address.
- penable  in  1  APB access phase.
- pwrite  in  1  1 = write.
- pwdata  in  32  write data.
- prdata  out  32  read data, registered.
- pready  out  1  tied 1; no wait states.
- pslverr  out  1  tied 0.
- led  out  CH  PWM outputs, registered, active-high.
- PWM_IRQ  out  1  level interrupt = STATUS.PD & CTRL.IE.

## Operation
Register map (offsets). Unmapped offsets read 0; writes to them are ignored; unused bits read 0.
- 0x000 CTRL: bit0 EN, bit1 IE. R/W. Reset 0.
- 0x004 PERIOD: [15:0] staging period P. R/W. Reset 0xFFFF.
- 0x008 PRESC: [15:0] prescaler. Live, not buffered. R/W. Reset 0.
- 0x00C STATUS: bit0 PD, period-done, sticky. Write 1 clears; write 0 has no effect.
- 0x010+4*i DUTY_i, i < CH: [15:0] staging duty. R/W. Reset 0. Reads return the staging value.

APB access:
- Write commits on the edge where psel & penable & pwrite.
- Read: prdata is loaded on the edge where psel & ~penable & ~pwrite (setup phase). It holds until the next such edge.

Datapath (all 16-bit unsigned):
- pre_cnt counts 0..PRESC, then wraps to 0. tick = EN & (pre_cnt == PRESC).
- On each tick:
  - If cnt == P_act: cnt <= 0, load P_act <= PERIOD and duty_act[i] <= DUTY_i for all i, set PD.
  - Otherwise cnt <= cnt + 1.
- While EN = 0:
  - pre_cnt and cnt are held at 0.
  - Active registers track the staging registers every cycle, so the first period after enable uses the current values.
- led[i] <= EN & (cnt < duty_act[i]).
  - duty_act = 0 gives constant low.
  - duty_act > P_act gives constant high.
  - Waveform period = (P_act+1)*(PRESC+1) pclk cycles; high time = duty_act*(PRESC+1) pclk cycles.
- P_act = 0: every tick is a boundary, so PD sets every tick. Outputs are then constant high or low.

## Timing
- Reset values:
  - prdata = 0, led = 0, PWM_IRQ = 0.
  - cnt = 0, pre_cnt = 0.
  - P_act = 0xFFFF, duty_act = 0.
- Enable latency: write CTRL.EN = 1 at edge T.
  - EN = 1 from T+1. First tick at T+1+PRESC.
  - led first reflects cnt = 0 at edge T+1, i.e. led high from T+2 if duty_act > 0.
- Disable: clearing EN forces led = 0 at the next edge. cnt and pre_cnt return to 0 on that same edge.
- Shadowing: a PERIOD or DUTY write mid-period takes effect only on the boundary tick, with the new led value one cycle later. A write landing on the same edge as the boundary tick is taken by that load.
- PRESC writes take effect on the next cycle. If the new PRESC is below the current pre_cnt, pre_cnt continues to 0xFFFF and wraps; this is intended and software must avoid it.
- PD set and write-1-clear on the same edge: set wins.
- PWM_IRQ is combinational from registered PD and IE. No added latency.
- preset asserted mid-period returns every register to its reset value on the next edge, regardless of APB activity.

## Test plan
- Reset, then read all registers:
  - CTRL = 0, PERIOD = 0x0000FFFF, PRESC = 0, STATUS = 0, DUTY_i = 0.
  - led = 0, PWM_IRQ = 0, pready = 1, pslverr = 0.
- Basic waveform: PRESC = 0, PERIOD = 9, DUTY0 = 3, DUTY1 = 0, DUTY2 = 10, CTRL = 1.
  - led0 is high 3 cycles, low 7 cycles, repeating every 10 cycles.
  - led1 is always low; led2 is always high.
- Prescaler: PRESC = 2, PERIOD = 3, DUTY0 = 2, enable.
  - Period is 12 cycles; led0 high for 6 of them.
  - The PD set edges are 12 cycles apart.
- Shadowing: while running with PERIOD = 9, DUTY0 = 3, write DUTY0 = 7 at cnt = 2.
  - The current period keeps 3 high cycles; the next period has 7.
  - Readback of DUTY0 = 7 immediately.
- Interrupt: IE = 1, EN = 1.
  - PWM_IRQ rises with PD at the first boundary.
  - Write STATUS = 1 between boundaries: PWM_IRQ low the next cycle.
  - Issue the clear on the boundary edge: PD stays 1.
  - Write STATUS = 0: no change.
- Disable and reset: clear EN mid-period, then led = 0 the next cycle and cnt = 0. Re-enable and the waveform restarts from cnt = 0. Assert preset while running: all outputs and registers return to reset values on the next edge.
